// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: parity modes,
// receiver FSM states and the layout of one receive FIFO entry.
package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_EVEN   = 1;
  localparam int PARITY_ODD    = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Data is held at the widest frame size; narrower frames are zero-extended.
  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     frame_err;
    logic                     parity_err;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        wr_ptr_reg                  <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: synchroniser, mid-bit sampling FSM with
// optional parity, and a receive FIFO behind a valid/ready handshake.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_frame_err,
  output logic                 out_parity_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int IDX_W   = $clog2(DATA_BITS);
  localparam int ENTRY_W = $bits(rx_entry_t);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic [1:0]           sync_reg;
  logic                 rx_s;
  rx_state_t            state_reg;
  rx_state_t            state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_err_reg;
  logic                 overrun_reg;
  logic                 bit_done;
  logic                 half_done;
  logic                 cnt_wrap;
  logic                 par_xor;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  rx_entry_t            entry;
  rx_entry_t            head_entry;
  logic                 unused_head;

  assign rx_s      = sync_reg[1];
  assign bit_done  = (cnt_reg == CNT_LAST);
  assign half_done = (cnt_reg == CNT_HALF);
  assign cnt_wrap  = (state_reg == RX_START) ? half_done : bit_done;
  assign par_xor   = (^shift_reg) ^ rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RX_IDLE:   if (!rx_s) state_next = RX_START;
      RX_START:  if (half_done) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (bit_done && idx_reg == IDX_LAST)
                   state_next = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (bit_done) state_next = RX_STOP;
      RX_STOP:   if (bit_done) state_next = RX_IDLE;
      default:   state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_reg != RX_IDLE);
    push             = (state_reg == RX_STOP) && bit_done;
    entry            = '0;
    entry.data       = MAX_DATA_BITS'(shift_reg);
    entry.frame_err  = ~rx_s;
    entry.parity_err = parity_err_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      parity_err_reg <= 1'b0;
    end else begin
      if (state_reg == RX_IDLE || cnt_wrap) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      if (state_reg != RX_DATA) begin
        idx_reg <= '0;
      end else if (bit_done) begin
        idx_reg   <= idx_reg + IDX_W'(1);
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end

      if (state_reg == RX_IDLE) begin
        parity_err_reg <= 1'b0;
      end else if (state_reg == RX_PARITY && bit_done) begin
        parity_err_reg <= (PARITY == PARITY_ODD) ? ~par_xor : par_xor;
      end
    end
  end

  assign pop = out_ready && !fifo_empty;

  // A full FIFO only drops the frame when nothing is leaving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun_reg <= 1'b1;
    end else if (overrun_clr) begin
      overrun_reg <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(entry),
    .pop      (pop),
    .head     (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_data       = head_entry.data[DATA_BITS-1:0];
  assign out_frame_err  = head_entry.frame_err;
  assign out_parity_err = head_entry.parity_err;
  assign out_valid      = !fifo_empty;
  assign overrun        = overrun_reg;
  assign unused_head    = ^head_entry.data;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: three instances (no/even/odd parity),
// 8 data bits, 10 clocks per bit, each fed from its own serial line.
module tb_uart_rx_core;

  logic            clk;
  logic            reset;
  logic [2:0]      rx_v;
  logic [2:0]      ready_v;
  logic            overrun_clr;
  logic [2:0][7:0] data_v;
  logic [2:0]      fe_v;
  logic [2:0]      pe_v;
  logic [2:0]      valid_v;
  logic [2:0]      overrun_v;
  logic [2:0]      busy_v;

  int checks = 0;
  int errors = 0;
  int wait_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    uart_rx_core #(
      .CLKS_PER_BIT(10),
      .DATA_BITS   (8),
      .PARITY      (gi),
      .FIFO_DEPTH  (4)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .rx            (rx_v[gi]),
      .out_data      (data_v[gi]),
      .out_frame_err (fe_v[gi]),
      .out_parity_err(pe_v[gi]),
      .out_valid     (valid_v[gi]),
      .out_ready     (ready_v[gi]),
      .overrun       (overrun_v[gi]),
      .overrun_clr   (overrun_clr),
      .busy          (busy_v[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                            input logic par_bit, input logic stop_bit);
    rx_v[sel] = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_v[sel] = d[i];
      repeat (10) @(negedge clk);
    end
    if (has_par) begin
      rx_v[sel] = par_bit;
      repeat (10) @(negedge clk);
    end
    rx_v[sel] = stop_bit;
    repeat (10) @(negedge clk);
    rx_v[sel] = 1'b1;
    $display("sent inst=%0d data=0x%02h par=%0d/%0b stop=%0b", sel, d, has_par, par_bit, stop_bit);
  endtask

  task automatic pop_one(input int sel);
    $display("pop  inst=%0d data=0x%02h fe=%0b pe=%0b", sel, data_v[sel], fe_v[sel], pe_v[sel]);
    ready_v[sel] = 1'b1;
    @(negedge clk);
    ready_v[sel] = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    rx_v        = 3'b111;
    ready_v     = 3'b000;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_valid",   valid_v[0],   1'b0);
    check("rst_data",    data_v[0],    8'h00);
    check("rst_fe_pe",   {fe_v[0], pe_v[0]}, 2'b00);
    check("rst_overrun", overrun_v[0], 1'b0);
    check("rst_busy",    busy_v[0],    1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single 8N1 frame; out_valid must rise on the edge where busy falls.
    fork
      send_frame(0, 8'h41, 1'b0, 1'b0, 1'b1);
      begin
        wait_n = 0;
        while (busy_v[0] !== 1'b1 && wait_n < 200) begin @(negedge clk); wait_n++; end
        while (busy_v[0] !== 1'b0 && wait_n < 200) begin @(negedge clk); wait_n++; end
        check("busy_fall_in_time", (wait_n < 200), 1'b1);
        check("valid_at_stop",     valid_v[0], 1'b1);
      end
    join
    check("f41_data", data_v[0], 8'h41);
    check("f41_flags", {fe_v[0], pe_v[0]}, 2'b00);
    pop_one(0);
    check("f41_popped", valid_v[0], 1'b0);

    // Back-to-back frames, held until both are in.
    send_frame(0, 8'h41, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    check("b2b_overrun", overrun_v[0], 1'b0);
    check("b2b_first",   data_v[0], 8'h41);
    pop_one(0);
    check("b2b_second",  data_v[0], 8'h22);
    check("b2b_second_valid", valid_v[0], 1'b1);
    pop_one(0);
    check("b2b_empty",   valid_v[0], 1'b0);

    // Three-cycle glitch: a false start that must not push anything.
    rx_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_busy_high", busy_v[0], 1'b1);
    repeat (20) @(negedge clk);
    check("glitch_busy_low", busy_v[0], 1'b0);
    check("glitch_no_push",  valid_v[0], 1'b0);

    // Parity: 0x07 has three ones.
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    check("even_p0_data", data_v[1], 8'h07);
    check("even_p0_err",  pe_v[1], 1'b1);
    pop_one(1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    check("even_p1_err",  pe_v[1], 1'b0);
    check("even_p1_fe",   fe_v[1], 1'b0);
    pop_one(1);
    send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1);
    check("odd_p0_err",   pe_v[2], 1'b0);
    pop_one(2);
    send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1);
    check("odd_p1_err",   pe_v[2], 1'b1);
    check("odd_p1_data",  data_v[2], 8'h07);
    pop_one(2);

    // Framing error followed by a normal frame.
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("fe_data", data_v[0], 8'h55);
    check("fe_flag", fe_v[0], 1'b1);
    pop_one(0);
    check("fe_single_entry", valid_v[0], 1'b0);
    send_frame(0, 8'h10, 1'b0, 1'b0, 1'b1);
    check("after_fe_data", data_v[0], 8'h10);
    check("after_fe_flag", fe_v[0], 1'b0);
    pop_one(0);

    // Five frames into a four-deep FIFO.
    for (int k = 1; k <= 5; k++) begin
      send_frame(0, 8'(k), 1'b0, 1'b0, 1'b1);
    end
    check("ovr_set",  overrun_v[0], 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr",  overrun_v[0], 1'b0);
    check("ovr_e1",   data_v[0], 8'h01);
    pop_one(0);
    check("ovr_e2",   data_v[0], 8'h02);
    pop_one(0);
    check("ovr_e3",   data_v[0], 8'h03);
    pop_one(0);
    check("ovr_e4",   data_v[0], 8'h04);
    check("ovr_e4_valid", valid_v[0], 1'b1);

    // Reset mid-frame while entry 4 is still queued.
    rx_v[0] = 1'b0;
    repeat (35) @(negedge clk);
    check("mid_busy", busy_v[0], 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", valid_v[0], 1'b0);
    check("mid_rst_busy",  busy_v[0],  1'b0);
    check("mid_rst_data",  data_v[0],  8'h00);
    rx_v[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    check("recover_data",  data_v[0], 8'h3C);
    check("recover_valid", valid_v[0], 1'b1);
    pop_one(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver that replaces the fixed 8N1, 10-clock-per-bit receive path feeding the processor's host link. It synchronises the asynchronous `rx` line and samples each bit at mid-period. It checks optional parity and the stop bit, then buffers received words with their error flags in a small FIFO behind a valid/ready handshake. The block sits between the board `rx` pin and the processor's data loader; the loader drains words at its own pace.

## Interface
- `CLKS_PER_BIT`, 10, clock cycles per bit; legal range ≥4.
- `DATA_BITS`, 8, data bits per frame (5..9), sent LSB first.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `FIFO_DEPTH`, 4, receive FIFO entries; must be a power of two, ≥2.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high reset.
- `rx` in 1: serial line; idles high; asynchronous to `clk`.
- `out_data` out DATA_BITS: data of the head FIFO entry.
- `out_frame_err` out 1: head entry had its stop bit sampled low.
- `out_parity_err` out 1: head entry failed the parity check; always 0 when PARITY=0.
- `out_valid` out 1: FIFO is non-empty.
- `out_ready` in 1: consumer accepts the head entry when it is high together with `out_valid`.
- `overrun` out 1: sticky flag, set when a frame completes while the FIFO is full.
- `overrun_clr` in 1: clears `overrun`; if a set event occurs in the same cycle, the set wins.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser, giving `rx_s`. The synchroniser flops reset to 1.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP. A bit counter runs 0..CLKS_PER_BIT-1 and a bit index runs 0..DATA_BITS-1.
- IDLE:
  - Waits for `rx_s`=0 (level detect, since the line idles high).
  - Moves to START and clears the counter.
- START:
  - At count CLKS_PER_BIT/2 (integer division), re-samples `rx_s`.
  - If `rx_s`=1, the event is a glitch or false start; return to IDLE and push nothing.
  - Otherwise, clear the counter and go to DATA.
- DATA:
  - At each count CLKS_PER_BIT-1, shifts `rx_s` in at the MSB of a DATA_BITS shift register, so the first bit received ends up at bit 0.
  - After bit DATA_BITS-1, goes to PARITY if PARITY≠0, else to STOP.
- PARITY:
  - Samples one bit at count CLKS_PER_BIT-1.
  - Even mode: the error flag is the XOR of the data bits and the parity bit.
  - Odd mode: the flag is the inverse of that XOR.
- STOP:
  - Samples at count CLKS_PER_BIT-1 and sets `frame_err` = ~`rx_s`.
  - In the same cycle, pushes {data, frame_err, parity_err} and returns to IDLE.
  - A frame with a framing error is still pushed, with its flag set.
  - After a framing error, IDLE may immediately see `rx_s`=0 (a break condition). The receiver then re-enters START and repeats, validated by the mid-start sample.
- FIFO:
  - A pop occurs on `out_valid & out_ready`.
  - A push when full is dropped and sets `overrun`.
  - A push and a pop in the same cycle when full both succeed; `overrun` is not set.
- Reset mid-frame aborts the frame immediately: FSM returns to IDLE, FIFO empties, the partial word is discarded.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_frame_err`=0, `out_parity_err`=0.
  - `overrun`=0, `busy`=0, FSM in IDLE, FIFO empty.
- Let T0 be the first clock edge at which `rx_s` is low; this is 2–3 cycles after the pin falls.
  - `busy` is high from T0+1.
  - Data bit i is sampled at T0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
  - The stop bit is sampled N·CLKS_PER_BIT after the start sample, where N = DATA_BITS+1+(PARITY≠0).
- `out_valid` rises one cycle after the stop sample when the FIFO was empty. `busy` falls on the same edge.
- Back-to-back frames with no idle gap are received without loss: the receiver is back in IDLE half a bit before the stop bit ends.
- `out_data` and the flags are registered FIFO head outputs. They are stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Package `uart_pkg` holds:
  - the parity mode constants `PARITY_NONE`/`PARITY_EVEN`/`PARITY_ODD`;
  - the FSM state type `rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - the FIFO entry struct (data plus the two error flags).
- One sub-module, `uart_rx_fifo`: a synchronous FIFO parametrised by width and depth. It has push/pop/full/empty and uses pointers one bit wider than the address for full/empty detection.
- The FSM, bit counter and synchroniser stay in `uart_rx_core`.

## Test plan
- Defaults; line idle, then frame 0x41 (8N1, 100 ns/bit at a 10 ns clock) -> one entry: `out_data`=0x41, both flags 0. `out_valid` rises within 1 cycle of the stop sample.
- Two back-to-back frames 0x41 and 0x22, `out_ready` held 0 -> two entries, popped in order 0x41 then 0x22; `overrun` stays 0.
- Low pulse of 3 cycles on `rx` -> returns to IDLE; no push; `busy` pulses and clears.
- PARITY=1, frame 0x07 sent with parity bit 0 -> `out_parity_err`=1. The same frame with parity bit 1 -> flag 0. Repeat in odd mode with the expectations inverted.
- Frame 0x55 with the stop bit driven low -> entry 0x55 with `out_frame_err`=1. A following normal frame 0x10 is received correctly.
- FIFO_DEPTH=4, `out_ready`=0, 5 frames -> entries 1–4 retained and `overrun`=1. Assert `overrun_clr` -> `overrun`=0. Assert `reset` mid-frame -> `out_valid`=0 and `busy`=0 immediately.
